// File: rtl/ethphy_mdio_master_if.sv
// rtl/ethphy_mdio_master_if.sv - command/status bundle between register block and MDIO master (ETHPHY_MDIO_PRESUP_EN adds cmd_nopre)
interface ethphy_mdio_master_if;
  logic        cmd_start;
  logic        cmd_rd;
  logic [4:0]  cmd_phyad;
  logic [4:0]  cmd_regad;
  logic [15:0] cmd_wdata;
`ifdef ETHPHY_MDIO_PRESUP_EN
  logic        cmd_nopre;
`endif
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        rd_err;

  // register block side: issues commands, observes status
  modport master (
`ifdef ETHPHY_MDIO_PRESUP_EN
    output cmd_nopre,
`endif
    output cmd_start, cmd_rd, cmd_phyad, cmd_regad, cmd_wdata,
    input  busy, done, rdata, rd_err
  );

  // MDIO engine side: consumes commands, reports status
  modport slave (
`ifdef ETHPHY_MDIO_PRESUP_EN
    input  cmd_nopre,
`endif
    input  cmd_start, cmd_rd, cmd_phyad, cmd_regad, cmd_wdata,
    output busy, done, rdata, rd_err
  );
endinterface

// File: rtl/ethphy_mdio_master.sv
// rtl/ethphy_mdio_master.sv - IEEE 802.3 clause-22 MDIO master; ETHPHY_MDIO_PRESUP_EN enables preamble suppression
module ethphy_mdio_master #(
  parameter int CLK_DIV = 25
) (
  input  logic                 s_axi_clk,
  input  logic                 s_axi_rst,
  ethphy_mdio_master_if.slave  cmd_if,
  output logic                 mdio_clk_o,
  output logic                 mdio_data_o,
  output logic                 mdio_dir_o,
  input  logic                 mdio_data_i
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  logic [1:0]    state;
  logic [4:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [31:0]   tx_sh;
  logic          rd_q;
  logic [15:0]   rx_sh;
  logic          rx_err;
  logic          done_q;
  logic [15:0]   rdata_q;
  logic          rd_err_q;
  logic          nopre;
  logic [31:0]   frame_w;

`ifdef ETHPHY_MDIO_PRESUP_EN
  assign nopre = cmd_if.cmd_nopre;
`else
  assign nopre = 1'b0;
`endif

  // Read frames carry ones in TA/DATA so the released line idles high
  assign frame_w = {2'b01,
                    cmd_if.cmd_rd ? 2'b10 : 2'b01,
                    cmd_if.cmd_phyad,
                    cmd_if.cmd_regad,
                    cmd_if.cmd_rd ? 2'b11 : 2'b10,
                    cmd_if.cmd_rd ? 16'hFFFF : cmd_if.cmd_wdata};

  assign cmd_if.busy   = (state != ST_IDLE);
  assign cmd_if.done   = done_q;
  assign cmd_if.rdata  = rdata_q;
  assign cmd_if.rd_err = rd_err_q;

  // Frame sequencer: accept, MDC phase divider, bit shifting, read capture
  always_ff @(posedge s_axi_clk or posedge s_axi_rst) begin
    if (s_axi_rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      tx_sh       <= '0;
      rd_q        <= 1'b0;
      rx_sh       <= '0;
      rx_err      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      rd_err_q    <= 1'b0;
      mdio_clk_o  <= 1'b0;
      mdio_data_o <= 1'b1;
      mdio_dir_o  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        div_cnt <= '0;
        if (cmd_if.cmd_start) begin
          rd_q       <= cmd_if.cmd_rd;
          bit_cnt    <= '0;
          div_cnt    <= DIV_LOAD;
          mdio_clk_o <= 1'b0;
          mdio_dir_o <= 1'b1;
          if (nopre) begin
            state       <= ST_FRAME;
            mdio_data_o <= frame_w[31];
            tx_sh       <= {frame_w[30:0], 1'b1};
          end else begin
            state       <= ST_PRE;
            mdio_data_o <= 1'b1;
            tx_sh       <= frame_w;
          end
        end
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - DW'(1);
      end else if (!mdio_clk_o) begin
        // Rising MDC edge: PHY data is sampled here on reads
        div_cnt    <= DIV_LOAD;
        mdio_clk_o <= 1'b1;
        if (state == ST_FRAME && rd_q) begin
          if (bit_cnt == 5'd15)
            rx_err <= mdio_data_i;
          else if (bit_cnt >= 5'd16)
            rx_sh <= {rx_sh[14:0], mdio_data_i};
        end
      end else begin
        // Falling MDC edge: next bit starts, outputs may change only here
        div_cnt    <= DIV_LOAD;
        mdio_clk_o <= 1'b0;
        if (bit_cnt == 5'd31 && state == ST_FRAME) begin
          state       <= ST_IDLE;
          div_cnt     <= '0;
          done_q      <= 1'b1;
          mdio_dir_o  <= 1'b0;
          mdio_data_o <= 1'b1;
          if (rd_q) begin
            rdata_q  <= rx_sh;
            rd_err_q <= rx_err;
          end
        end else if (bit_cnt == 5'd31) begin
          state       <= ST_FRAME;
          bit_cnt     <= '0;
          mdio_data_o <= tx_sh[31];
          tx_sh       <= {tx_sh[30:0], 1'b1};
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
          if (state == ST_FRAME) begin
            mdio_data_o <= tx_sh[31];
            tx_sh       <= {tx_sh[30:0], 1'b1};
            mdio_dir_o  <= !(rd_q && bit_cnt >= 5'd13);
          end
        end
      end
    end
  end
endmodule
